// File: rtl/power_switch_emu_pkg.sv
// Shared types and helpers for the power-switch acknowledge emulator.
// Holds the per-channel state encoding and the latency-to-counter-load conversion.
package power_switch_emu_pkg;

    typedef enum logic [1:0] {
        ON        = 2'd0,
        GOING_OFF = 2'd1,
        OFF       = 2'd2,
        GOING_ON  = 2'd3
    } sw_state_e;

    localparam int LAT_W = 32;

    // A latency of 0 behaves like 1; the counter expires when it reaches 0,
    // so the load value is the effective latency minus one.
    function automatic logic [LAT_W-1:0] lat_sel(input logic [LAT_W-1:0] lat);
        return (lat == '0) ? '0 : lat - 1'b1;
    endfunction

endpackage

// File: rtl/power_switch_emu_ch.sv
// One emulated power switch: request/ack FSM with a countdown latency,
// glitch abort (a request that reverts before expiry never reaches the ack) and hold freeze.
module power_switch_emu_ch
    import power_switch_emu_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             switch_n_i,
    input  logic             hold_i,
    input  logic [CNT_W-1:0] on_lat_i,
    input  logic [CNT_W-1:0] off_lat_i,
    output logic             switch_ack_n_o,
    output logic             busy_o,
    output logic             abort_o
);

    sw_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort_q, abort_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ON;
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
        end
    end

    // Revert beats hold, hold beats expiry: a cancelled request never flips the ack.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        abort_d = 1'b0;
        unique case (state_q)
            ON: begin
                if (switch_n_i) begin
                    state_d = GOING_OFF;
                    cnt_d   = CNT_W'(lat_sel(LAT_W'(off_lat_i)));
                end
            end
            OFF: begin
                if (!switch_n_i) begin
                    state_d = GOING_ON;
                    cnt_d   = CNT_W'(lat_sel(LAT_W'(on_lat_i)));
                end
            end
            GOING_OFF: begin
                if (!switch_n_i) begin
                    state_d = ON;
                    abort_d = 1'b1;
                end else if (!hold_i) begin
                    if (cnt_q == '0) state_d = OFF;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            GOING_ON: begin
                if (switch_n_i) begin
                    state_d = OFF;
                    abort_d = 1'b1;
                end else if (!hold_i) begin
                    if (cnt_q == '0) state_d = ON;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            default: state_d = ON;
        endcase
    end

    // Outputs decode registered state only, so no input reaches an output combinationally.
    assign switch_ack_n_o = (state_q == OFF) || (state_q == GOING_ON);
    assign busy_o         = (state_q == GOING_OFF) || (state_q == GOING_ON);
    assign abort_o        = abort_q;

endmodule

// File: rtl/power_switch_emu.sv
// Multi-channel power-switch acknowledge emulator for the testharness.
// Selects the latency source once and fans it out to NUM_CH independent channels.
module power_switch_emu
    import power_switch_emu_pkg::*;
#(
    parameter int NUM_CH  = 3,
    parameter int CNT_W   = 8,
    parameter int ON_LAT  = 15,
    parameter int OFF_LAT = 15,
    parameter bit USE_CFG = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] switch_n_i,
    output logic [NUM_CH-1:0] switch_ack_n_o,
    input  logic [CNT_W-1:0]  cfg_on_lat_i,
    input  logic [CNT_W-1:0]  cfg_off_lat_i,
    input  logic [NUM_CH-1:0] hold_i,
    output logic [NUM_CH-1:0] busy_o,
    output logic [NUM_CH-1:0] abort_o
);

    logic [CNT_W-1:0] on_lat;
    logic [CNT_W-1:0] off_lat;

    assign on_lat  = USE_CFG ? cfg_on_lat_i  : CNT_W'(ON_LAT);
    assign off_lat = USE_CFG ? cfg_off_lat_i : CNT_W'(OFF_LAT);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        power_switch_emu_ch #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk_i          (clk_i),
            .rst_ni         (rst_ni),
            .switch_n_i     (switch_n_i[i]),
            .hold_i         (hold_i[i]),
            .on_lat_i       (on_lat),
            .off_lat_i      (off_lat),
            .switch_ack_n_o (switch_ack_n_o[i]),
            .busy_o         (busy_o[i]),
            .abort_o        (abort_o[i])
        );
    end

endmodule
